instr_issue_ctrl: RTL and testbench

//  Instruction-side initiator for the pipelined processor core. A host loads
//  32-bit instructions into an internal program FIFO. The block issues them one
//  at a time on the core's instruction input and waits for the core's

---
 rtl/proc_pkg.sv | 14 +
 rtl/instr_fifo.sv | 40 ++++
 rtl/instr_issue_ctrl.sv | 113 +++++++++++
 tb/tb_instr_issue_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: opcode set, legality check and issue FSM states shared by issue control and core decode
// Ports: none (package)
package proc_pkg;
   localparam logic [5:0] OP_ADD = 6'b000000;
   localparam logic [5:0] OP_SUB = 6'b000010;
   localparam logic [5:0] OP_AND = 6'b000100;
   localparam logic [5:0] OP_OR  = 6'b000101;
   localparam logic [5:0] OP_EQ  = 6'b001000;
   localparam logic [5:0] OP_NE  = 6'b001001;
   typedef enum logic [1:0] {IDLE, CHECK, ISSUE, WAIT_DONE} issue_state_t;
   function automatic logic is_legal_op(logic [5:0] op);
      return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_EQ, OP_NE};
   endfunction
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous program FIFO, DATA_WIDTH x FIFO_DEPTH, pointers one bit wider than the index
// Ports: clk, rst (sync, active-high), push/din (ignored when full), pop/dout (head, ignored when empty), full, empty
module instr_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [AW:0] wr_q, wr_d, rd_q, rd_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic do_push;
   always_comb begin
      empty = wr_q == rd_q;
      // same index with differing wrap bits means the writer has lapped the reader
      full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      do_push = push && !full;
      wr_d = do_push ? wr_q + 1'b1 : wr_q;
      rd_d = (pop && !empty) ? rd_q + 1'b1 : rd_q;
      dout = mem_q[rd_q[AW-1:0]];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
   always_ff @(posedge clk)
      if (do_push) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/instr_issue_ctrl.sv
// instr_issue_ctrl: issues queued instructions to the core one at a time, filtering illegal opcodes and watching for a hung core
// Ports: clk, rst (sync, active-high), enable; load_valid/load_data/load_ready host push;
//        instr_out/instr_valid/instr_ack core issue handshake; proc_done write-back pulse;
//        busy, issued_cnt (wraps), illegal_cnt (saturates), err_timeout (sticky)
module instr_issue_ctrl
   import proc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  load_valid,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_ready,
   output logic [DATA_WIDTH-1:0] instr_out,
   output logic                  instr_valid,
   input  logic                  instr_ack,
   input  logic                  proc_done,
   output logic                  busy,
   output logic [15:0]           issued_cnt,
   output logic [7:0]            illegal_cnt,
   output logic                  err_timeout
);
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
   issue_state_t state_q, state_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d, instr_out_q, instr_out_d, fifo_dout;
   logic instr_valid_q, instr_valid_d, err_q, err_d, pop, full, empty;
   logic [15:0] issued_q, issued_d;
   logic [7:0] illegal_q, illegal_d, wd_q, wd_d;
   instr_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (load_valid),
      .pop   (pop),
      .din   (load_data),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty)
   );
   always_comb begin
      state_d = state_q;
      hold_d = hold_q;
      instr_out_d = instr_out_q;
      instr_valid_d = instr_valid_q;
      issued_d = issued_q;
      illegal_d = illegal_q;
      err_d = err_q;
      wd_d = wd_q;
      pop = 1'b0;
      case (state_q)
         IDLE: if (enable && !empty) begin
            pop = 1'b1;
            hold_d = fifo_dout;
            state_d = CHECK;
         end
         CHECK: if (!is_legal_op(hold_q[DATA_WIDTH-1 -: 6])) begin
            illegal_d = (illegal_q == 8'hFF) ? illegal_q : illegal_q + 8'd1;
            state_d = IDLE;
         end else begin
            instr_out_d = hold_q;
            instr_valid_d = 1'b1;
            state_d = ISSUE;
         end
         ISSUE: if (instr_ack && instr_valid_q) begin
            instr_valid_d = 1'b0;
            issued_d = issued_q + 16'd1;
            wd_d = '0;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            wd_d = wd_q + 8'd1;
            // completion wins over a timeout landing on the same cycle
            if (proc_done) state_d = IDLE;
            else if (wd_q == WD_LAST) begin
               err_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         hold_q <= '0;
         instr_out_q <= '0;
         instr_valid_q <= 1'b0;
         issued_q <= '0;
         illegal_q <= '0;
         err_q <= 1'b0;
         wd_q <= '0;
      end else begin
         state_q <= state_d;
         hold_q <= hold_d;
         instr_out_q <= instr_out_d;
         instr_valid_q <= instr_valid_d;
         issued_q <= issued_d;
         illegal_q <= illegal_d;
         err_q <= err_d;
         wd_q <= wd_d;
      end
   end
   assign load_ready = !full;
   assign busy = (state_q != IDLE) || !empty;
   assign instr_out = instr_out_q;
   assign instr_valid = instr_valid_q;
   assign issued_cnt = issued_q;
   assign illegal_cnt = illegal_q;
   assign err_timeout = err_q;
endmodule

// File: tb/tb_instr_issue_ctrl.sv
// tb_instr_issue_ctrl: directed vectors, multi-cycle corner sequences and a randomized run against a stream-level model
module tb_instr_issue_ctrl;
   localparam int TIMEOUT = 15;
   logic clk = 1'b0;
   logic rst, enable, load_valid, instr_ack, proc_done;
   logic [31:0] load_data;
   logic load_ready, instr_valid, busy, err_timeout;
   logic [31:0] instr_out;
   logic [15:0] issued_cnt;
   logic [7:0] illegal_cnt;
   int checks = 0, errors = 0;

   instr_issue_ctrl #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .instr_ack   (instr_ack),
      .proc_done   (proc_done),
      .busy        (busy),
      .issued_cnt  (issued_cnt),
      .illegal_cnt (illegal_cnt),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic [31:0] word;
      bit          legal;
   } vec_t;

   function automatic bit legal_op(logic [31:0] w);
      logic [5:0] op;
      op = w[31:26];
      return op == 6'd0 || op == 6'd2 || op == 6'd4 || op == 6'd5 || op == 6'd8 || op == 6'd9;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0] ops [6];
      logic [5:0] op;
      ops = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd9};
      op = ($urandom_range(9, 0) < 7) ? ops[$urandom_range(5, 0)] : 6'($urandom);
      return {op, 26'($urandom)};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      load_valid = 1'b0;
      instr_ack = 1'b0;
      proc_done = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic push(logic [31:0] w);
      load_valid = 1'b1;
      load_data = w;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic wait_valid(int bound);
      int n = 0;
      while (!instr_valid && n < bound) begin
         tick();
         n++;
      end
      chk("wait_valid", instr_valid, 1);
   endtask

   task automatic ack_done();
      instr_ack = 1'b1;
      tick();
      instr_ack = 1'b0;
      tick();
      proc_done = 1'b1;
      tick();
      proc_done = 1'b0;
   endtask

   initial begin
      vec_t tbl [11];
      logic [31:0] words [16];
      int exp_iss, exp_ill;
      logic [31:0] mq [$];
      int m_issued, m_illegal, since, lat, left_legal;
      bit m_err, in_fl, push_acc, ack_acc;

      tbl[0]  = '{32'h0000_0000, 1'b1};
      tbl[1]  = '{32'hFC00_0000, 1'b0};
      tbl[2]  = '{32'h0800_0000, 1'b1};
      tbl[3]  = '{32'h1012_3456, 1'b1};
      tbl[4]  = '{32'h1400_00FF, 1'b1};
      tbl[5]  = '{32'h2000_0001, 1'b1};
      tbl[6]  = '{32'h2400_0002, 1'b1};
      tbl[7]  = '{32'h0400_0000, 1'b0};
      tbl[8]  = '{32'h0C00_0000, 1'b0};
      tbl[9]  = '{32'h2800_0000, 1'b0};
      tbl[10] = '{32'h1800_0000, 1'b0};

      enable = 1'b1;
      load_data = '0;
      do_reset();
      chk("rst_valid", instr_valid, 0);
      chk("rst_out", instr_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", load_ready, 1);
      chk("rst_issued", issued_cnt, 0);
      chk("rst_illegal", illegal_cnt, 0);
      chk("rst_err", err_timeout, 0);

      exp_iss = 0;
      exp_ill = 0;
      for (int i = 0; i < 11; i++) begin
         push(tbl[i].word);
         chk("tbl_valid_n", instr_valid, 0);
         tick();
         chk("tbl_valid_n1", instr_valid, 0);
         tick();
         chk("tbl_valid_n2", instr_valid, tbl[i].legal);
         chk("tbl_busy_n2", busy, tbl[i].legal);
         if (tbl[i].legal) begin
            chk("tbl_out", instr_out, tbl[i].word);
            ack_done();
            exp_iss++;
         end else exp_ill++;
         chk("tbl_issued", issued_cnt, exp_iss);
         chk("tbl_illegal", illegal_cnt, exp_ill);
         chk("tbl_busy_end", busy, 0);
      end

      // done on the very cycle the watchdog expires counts as completion
      do_reset();
      push(32'h0800_0011);
      wait_valid(6);
      instr_ack = 1'b1;
      tick();
      instr_ack = 1'b0;
      for (int k = 1; k < TIMEOUT; k++) tick();
      proc_done = 1'b1;
      tick();
      proc_done = 1'b0;
      chk("edge_done_err", err_timeout, 0);
      chk("edge_done_busy", busy, 0);

      // withheld completion times out; the queued instruction still issues
      push(32'h1000_0001);
      push(32'h1400_0002);
      wait_valid(6);
      chk("to_first", instr_out, 32'h1000_0001);
      instr_ack = 1'b1;
      tick();
      instr_ack = 1'b0;
      for (int k = 1; k < TIMEOUT; k++) tick();
      chk("to_err_before", err_timeout, 0);
      chk("to_busy_before", busy, 1);
      tick();
      chk("to_err_after", err_timeout, 1);
      wait_valid(6);
      chk("to_second", instr_out, 32'h1400_0002);
      ack_done();
      chk("to_issued", issued_cnt, 3);
      chk("to_err_sticky", err_timeout, 1);

      // fill to full, then push and pop on the same edge
      do_reset();
      enable = 1'b0;
      for (int i = 0; i < 16; i++) begin
         words[i] = {(i % 3 == 0) ? 6'd0 : (i % 3 == 1) ? 6'd5 : 6'd9, 26'(i * 1111 + 7)};
         push(words[i]);
      end
      chk("fill_ready", load_ready, 0);
      chk("fill_busy", busy, 1);
      chk("fill_valid", instr_valid, 0);
      load_valid = 1'b1;
      load_data = 32'h0000_BEEF;
      enable = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         wait_valid(10);
         chk("fill_order", instr_out, words[i]);
         ack_done();
      end
      repeat (6) tick();
      chk("fill_no17", instr_valid, 0);
      chk("fill_busy_end", busy, 0);
      chk("fill_issued", issued_cnt, 16);

      // reset while an instruction waits for ack with five more queued
      do_reset();
      push(32'h2000_0005);
      push(32'hFC00_0000);
      wait_valid(6);
      ack_done();
      repeat (3) tick();
      chk("mid_pre_issued", issued_cnt, 1);
      chk("mid_pre_illegal", illegal_cnt, 1);
      enable = 1'b0;
      for (int i = 0; i < 6; i++) push({6'd2, 26'(i)});
      enable = 1'b1;
      wait_valid(6);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_valid", instr_valid, 0);
      chk("mid_busy", busy, 0);
      chk("mid_issued", issued_cnt, 0);
      chk("mid_illegal", illegal_cnt, 0);
      chk("mid_ready", load_ready, 1);
      chk("mid_out", instr_out, 0);
      repeat (5) tick();
      chk("mid_discard", busy, 0);

      // stray completion pulse while idle
      push(32'h2400_0003);
      wait_valid(6);
      ack_done();
      proc_done = 1'b1;
      tick();
      tick();
      proc_done = 1'b0;
      tick();
      chk("idle_done_issued", issued_cnt, 1);
      chk("idle_done_err", err_timeout, 0);
      chk("idle_done_busy", busy, 0);

      // randomized traffic against a stream-level model
      do_reset();
      m_issued = 0;
      m_illegal = 0;
      m_err = 1'b0;
      in_fl = 1'b0;
      since = 0;
      lat = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         bit drain;
         drain = cyc >= 3000;
         chk("rnd_err", err_timeout, m_err);
         chk("rnd_issued", issued_cnt, m_issued);
         chk("rnd_one_in_flight", instr_valid && in_fl, 0);
         load_valid = !drain && $urandom_range(1, 0) == 1;
         load_data = rand_instr();
         enable = drain || $urandom_range(3, 0) != 0;
         instr_ack = instr_valid ? $urandom_range(9, 0) < 6 : $urandom_range(9, 0) < 1;
         proc_done = in_fl ? (since + 1 == lat) : ($urandom_range(19, 0) == 0);
         push_acc = load_valid && load_ready;
         ack_acc = instr_ack && instr_valid;
         if (ack_acc) begin
            while (mq.size() > 0 && !legal_op(mq[0])) begin
               void'(mq.pop_front());
               m_illegal++;
            end
            chk("rnd_have_instr", mq.size() > 0, 1);
            if (mq.size() > 0) chk("rnd_instr", instr_out, mq.pop_front());
         end
         tick();
         if (push_acc) mq.push_back(load_data);
         if (in_fl) begin
            since++;
            if (since == lat) in_fl = 1'b0;
            else if (since == TIMEOUT) begin
               m_err = 1'b1;
               in_fl = 1'b0;
            end
         end
         if (ack_acc) begin
            m_issued++;
            in_fl = 1'b1;
            since = 0;
            case ($urandom_range(9, 0))
               0: lat = TIMEOUT;
               1: lat = 99;
               default: lat = $urandom_range(8, 1);
            endcase
         end
      end
      proc_done = 1'b0;
      instr_ack = 1'b0;
      left_legal = 0;
      while (mq.size() > 0) begin
         if (legal_op(mq[0])) left_legal++;
         else m_illegal++;
         void'(mq.pop_front());
      end
      chk("rnd_leftover", left_legal, 0);
      chk("rnd_illegal", illegal_cnt, (m_illegal > 255) ? 255 : m_illegal);
      chk("rnd_final_issued", issued_cnt, m_issued);
      chk("rnd_final_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
